// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: one barrier actuator shared by the entry and exit
// lanes. It grants the gate to one lane at a time, sequences the barrier
// through open / wait-for-pass / close, and tracks lot occupancy.
// Optional feature macro: PARK_CLOSE_TIMEOUT_EN adds a close timeout that
// latches into a FAULT state; only rst clears it.
module parking_gate_arbiter #(
  parameter int CAPACITY      = 16,
  parameter int CNT_W         = 5,
  parameter int PASS_TIMEOUT  = 64,
  parameter int CLOSE_TIMEOUT = 32,
  parameter int TMR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             entry_pass,
  input  logic             exit_pass,
  input  logic             gate_closed,
  output logic             entry_gnt,
  output logic             exit_gnt,
  output logic             gate_open_cmd,
  output logic             gate_close_cmd,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             timeout_alarm,
  output logic             gate_fault
);

  // Parameter sanity: these empty blocks only show up in the elaborated
  // hierarchy when a counter is too narrow for its limit.
  localparam int TMR_NEED = (PASS_TIMEOUT > CLOSE_TIMEOUT) ? PASS_TIMEOUT : CLOSE_TIMEOUT;
  if ((1 << TMR_W) < TMR_NEED) begin : g_tmr_w_too_small
  end
  if ((1 << CNT_W) <= CAPACITY) begin : g_cnt_w_too_small
  end

  localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

`ifdef PARK_CLOSE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_TIMEOUT - 1);
  typedef enum logic [1:0] {S_IDLE, S_PASS, S_CLOSE, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PASS, S_CLOSE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] occupancy_reg, occupancy_next;
  logic             favour_exit_reg, favour_exit_next;
  logic             entry_gnt_reg, entry_gnt_next;
  logic             exit_gnt_reg, exit_gnt_next;
  logic             open_reg, open_next;
  logic             close_reg, close_next;
  logic             alarm_reg, alarm_next;

  logic elig_entry, elig_exit, any_elig, pick_exit;
  logic pass_seen, pass_expired;

  // A full lot leaves the entry request pending rather than rejecting it.
  assign lot_full     = (occupancy_reg >= CAP_VAL);
  assign elig_entry   = entry_req & ~lot_full;
  assign elig_exit    = exit_req;
  assign any_elig     = elig_entry | elig_exit;
  assign pick_exit    = elig_exit & (~elig_entry | favour_exit_reg);
  // Only the granted lane's sensor counts; the other lane's is ignored.
  assign pass_seen    = (entry_gnt_reg & entry_pass) | (exit_gnt_reg & exit_pass);
  assign pass_expired = (timer_reg == PASS_LAST);

`ifdef PARK_CLOSE_TIMEOUT_EN
  logic fault_reg, fault_next;
  logic close_expired;
  assign close_expired = (timer_reg == CLOSE_LAST);
  assign gate_fault    = fault_reg;
`else
  assign gate_fault    = 1'b0;
`endif

  // State and output registers; reset parks everything and favours exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      timer_reg       <= '0;
      occupancy_reg   <= '0;
      favour_exit_reg <= 1'b1;
      entry_gnt_reg   <= 1'b0;
      exit_gnt_reg    <= 1'b0;
      open_reg        <= 1'b0;
      close_reg       <= 1'b0;
      alarm_reg       <= 1'b0;
`ifdef PARK_CLOSE_TIMEOUT_EN
      fault_reg       <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      occupancy_reg   <= occupancy_next;
      favour_exit_reg <= favour_exit_next;
      entry_gnt_reg   <= entry_gnt_next;
      exit_gnt_reg    <= exit_gnt_next;
      open_reg        <= open_next;
      close_reg       <= close_next;
      alarm_reg       <= alarm_next;
`ifdef PARK_CLOSE_TIMEOUT_EN
      fault_reg       <= fault_next;
`endif
    end
  end

  // Next-state selection for the gate sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_elig) state_next = S_PASS;
      S_PASS:  if (pass_seen || pass_expired) state_next = S_CLOSE;
      S_CLOSE: begin
        if (gate_closed) state_next = S_IDLE;
`ifdef PARK_CLOSE_TIMEOUT_EN
        else if (close_expired) state_next = S_FAULT;
`endif
      end
`ifdef PARK_CLOSE_TIMEOUT_EN
      S_FAULT: state_next = S_FAULT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, timer, occupancy and pointer.
  always_comb begin
    entry_gnt_next   = entry_gnt_reg;
    exit_gnt_next    = exit_gnt_reg;
    open_next        = open_reg;
    close_next       = close_reg;
    alarm_next       = 1'b0;
    timer_next       = timer_reg;
    occupancy_next   = occupancy_reg;
    favour_exit_next = favour_exit_reg;
`ifdef PARK_CLOSE_TIMEOUT_EN
    fault_next       = fault_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        entry_gnt_next = 1'b0;
        exit_gnt_next  = 1'b0;
        open_next      = 1'b0;
        close_next     = 1'b0;
        timer_next     = '0;
        if (any_elig) begin
          exit_gnt_next  = pick_exit;
          entry_gnt_next = ~pick_exit;
          open_next      = 1'b1;
        end
      end
      S_PASS: begin
        timer_next = timer_reg + 1'b1;
        if (pass_seen) begin
          // Saturate both ways; an exit at zero is sensor drift.
          if (entry_gnt_reg && occupancy_reg < CAP_VAL)
            occupancy_next = occupancy_reg + 1'b1;
          else if (exit_gnt_reg && occupancy_reg != '0)
            occupancy_next = occupancy_reg - 1'b1;
          open_next  = 1'b0;
          close_next = 1'b1;
          timer_next = '0;
        end else if (pass_expired) begin
          alarm_next = 1'b1;
          open_next  = 1'b0;
          close_next = 1'b1;
          timer_next = '0;
        end
      end
      S_CLOSE: begin
`ifdef PARK_CLOSE_TIMEOUT_EN
        timer_next = timer_reg + 1'b1;
`endif
        if (gate_closed) begin
          close_next       = 1'b0;
          entry_gnt_next   = 1'b0;
          exit_gnt_next    = 1'b0;
          timer_next       = '0;
          favour_exit_next = entry_gnt_reg;
        end
`ifdef PARK_CLOSE_TIMEOUT_EN
        else if (close_expired) begin
          fault_next     = 1'b1;
          close_next     = 1'b1;
          entry_gnt_next = 1'b0;
          exit_gnt_next  = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

  assign entry_gnt      = entry_gnt_reg;
  assign exit_gnt       = exit_gnt_reg;
  assign gate_open_cmd  = open_reg;
  assign gate_close_cmd = close_reg;
  assign occupancy      = occupancy_reg;
  assign timeout_alarm  = alarm_reg;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Testbench for parking_gate_arbiter: table vectors plus hand sequences,
// expected outputs queued at drive time and compared after the edge.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst, entry_req, exit_req, entry_pass, exit_pass, gate_closed;
  logic       entry_gnt, exit_gnt, gate_open_cmd, gate_close_cmd;
  logic [4:0] occupancy;
  logic       lot_full, timeout_alarm, gate_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .exit_req(exit_req),
    .entry_pass(entry_pass), .exit_pass(exit_pass),
    .gate_closed(gate_closed),
    .entry_gnt(entry_gnt), .exit_gnt(exit_gnt),
    .gate_open_cmd(gate_open_cmd), .gate_close_cmd(gate_close_cmd),
    .occupancy(occupancy), .lot_full(lot_full),
    .timeout_alarm(timeout_alarm), .gate_fault(gate_fault)
  );

  typedef struct {
    logic       r, er, xr, ep, xp, gc;
    logic       eg, xg, op, cl, al, fl;
    logic [4:0] occ;
    logic       lf;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, er, xr, ep, xp, gc,
                              input logic eg, xg, op, cl, al, fl,
                              input int occ, input logic lf);
    vec_t v;
    v.r = r; v.er = er; v.xr = xr; v.ep = ep; v.xp = xp; v.gc = gc;
    v.eg = eg; v.xg = xg; v.op = op; v.cl = cl; v.al = al; v.fl = fl;
    v.occ = 5'(occ); v.lf = lf;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    logic [11:0] got, want;
    rst = v.r; entry_req = v.er; exit_req = v.xr;
    entry_pass = v.ep; exit_pass = v.xp; gate_closed = v.gc;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got  = {entry_gnt, exit_gnt, gate_open_cmd, gate_close_cmd, timeout_alarm,
            gate_fault, lot_full, occupancy};
    want = {e.eg, e.xg, e.op, e.cl, e.al, e.fl, e.lf, e.occ};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got eg,xg,op,cl,al,fl,lf,occ=%b%b%b%b%b%b%b,%0d want %b%b%b%b%b%b%b,%0d",
               name, got[11], got[10], got[9], got[8], got[7], got[6], got[5], got[4:0],
               want[11], want[10], want[9], want[8], want[7], want[6], want[5], want[4:0]);
    end else begin
      $display("ok   %s: eg=%b xg=%b op=%b cl=%b al=%b fl=%b lf=%b occ=%0d",
               name, entry_gnt, exit_gnt, gate_open_cmd, gate_close_cmd,
               timeout_alarm, gate_fault, lot_full, occupancy);
    end
  endtask

  initial begin
    // Single entry: grant, pass, close, back to idle.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 1,0,0,1,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,1,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0));
    // Both lanes requesting: exit, entry, exit; no underflow at zero.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,1,1,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 0,1,0,1,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,1,0,0, 1,0,0,1,0,0, 1,0));
    tbl.push_back(mk(0,0,1,0,0,1, 0,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,1,1,0,0,0, 1,0));
    tbl.push_back(mk(0,1,0,0,1,0, 0,1,0,1,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,0));
    // Exit sensor during an entry grant is ignored.
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 1,0,0,1,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 1,0));
    // Reset while in PASS clears grant and occupancy.
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,1,0,0,0, 1,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,0));

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Fill the lot to capacity.
    for (int i = 0; i < 16; i++) begin
      step("fill_gnt",   mk(0,1,0,0,0,0, 1,0,1,0,0,0, i,   1'b0));
      step("fill_pass",  mk(0,0,0,1,0,0, 1,0,0,1,0,0, i+1, (i+1) >= 16));
      step("fill_close", mk(0,0,0,0,0,1, 0,0,0,0,0,0, i+1, (i+1) >= 16));
    end
    // Full: entry stays pending with no grant.
    for (int i = 0; i < 3; i++)
      step("full_block", mk(0,1,0,0,0,0, 0,0,0,0,0,0, 16,1));
    step("full_exit_gnt", mk(0,1,1,0,0,0, 0,1,1,0,0,0, 16,1));
    step("full_exit_pass", mk(0,1,0,0,1,0, 0,1,0,1,0,0, 15,0));
    step("full_exit_close", mk(0,1,0,0,0,1, 0,0,0,0,0,0, 15,0));
    step("full_entry_gnt", mk(0,1,0,0,0,0, 1,0,1,0,0,0, 15,0));
    step("full_entry_pass", mk(0,0,0,1,0,0, 1,0,0,1,0,0, 16,1));
    step("full_entry_close", mk(0,0,0,0,0,1, 0,0,0,0,0,0, 16,1));

    // Pass timeout: alarm exactly 64 edges after the grant edge.
    step("to_rst", mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    step("to_gnt", mk(0,1,0,0,0,0, 1,0,1,0,0,0, 0,0));
    for (int k = 1; k < 64; k++)
      step("to_wait", mk(0,0,0,0,0,0, 1,0,1,0,0,0, 0,0));
    step("to_alarm", mk(0,0,0,0,0,0, 1,0,0,1,1,0, 0,0));
    step("to_after", mk(0,0,0,0,0,0, 1,0,0,1,0,0, 0,0));
    step("to_close", mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,0));

`ifdef PARK_CLOSE_TIMEOUT_EN
    // Close timeout: FAULT after 32 CLOSE cycles, requests ignored until rst.
    step("flt_gnt",  mk(0,0,1,0,0,0, 0,1,1,0,0,0, 0,0));
    step("flt_pass", mk(0,0,0,0,1,0, 0,1,0,1,0,0, 0,0));
    for (int k = 1; k < 32; k++)
      step("flt_wait", mk(0,0,0,0,0,0, 0,1,0,1,0,0, 0,0));
    step("flt_enter", mk(0,0,0,0,0,0, 0,0,0,1,0,1, 0,0));
    step("flt_ignore", mk(0,1,1,0,0,1, 0,0,0,1,0,1, 0,0));
    step("flt_rst", mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
